// File: rtl/demux1to4_buf_pkg.sv
// Shared definitions for the buffered 1-to-4 demultiplexer.
//   NUM_CH       : number of output channels
//   CH1..CH4     : in_sel encodings for each output channel
//   sel_decode() : one-hot push-enable vector for a given in_sel
package demux1to4_buf_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH1 = 2'b00;
    localparam logic [1:0] CH2 = 2'b01;
    localparam logic [1:0] CH3 = 2'b10;
    localparam logic [1:0] CH4 = 2'b11;

    function automatic logic [NUM_CH-1:0] sel_decode(input logic [1:0] sel);
        logic [NUM_CH-1:0] onehot;
        onehot = '0;
        case (sel)
            CH1:     onehot = 4'b0001;
            CH2:     onehot = 4'b0010;
            CH3:     onehot = 4'b0100;
            CH4:     onehot = 4'b1000;
            default: onehot = '0;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-channel FIFO used by each output of demux1to4_buf.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_push     : write i_data (ignored when full, even if popping this cycle)
//   i_pop      : remove head (ignored when empty)
//   i_data     : word to write
//   o_full     : count == DEPTH
//   o_empty    : count == 0
//   o_head     : storage at read pointer (unmasked; caller masks when empty)
module demux_chan_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    // Full refuses a push regardless of a same-cycle pop, so in_ready never
    // depends on the consumer's ready.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/demux1to4_buf.sv
// Buffered 1-to-4 demultiplexer: steers each input word into one of four
// independently stalled output channels, each with its own FIFO.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   in_data/in_sel : word and destination channel (00->out1 .. 11->out4)
//   in_valid       : input word valid
//   in_ready       : selected channel not full (0 while in reset)
//   out1..out4     : channel head word, zero when the channel is empty
//   out_valid[k]   : channel k+1 non-empty
//   out_ready[k]   : consumer k+1 takes the head
module demux1to4_buf
    import demux1to4_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [1:0]        in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic [WIDTH-1:0]  out4,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready
);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_push;
    logic [WIDTH-1:0]  w_head [NUM_CH];
    logic [WIDTH-1:0]  w_out  [NUM_CH];

    // rst_n gating keeps in_ready low during reset even though the FIFO
    // flags already read empty.
    assign in_ready = rst_n && !w_full[in_sel];
    assign w_push   = sel_decode(in_sel) & {NUM_CH{in_valid && in_ready}};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[k]),
            .i_pop   (out_ready[k]),
            .i_data  (in_data),
            .o_full  (w_full[k]),
            .o_empty (w_empty[k]),
            .o_head  (w_head[k])
        );

        assign w_out[k] = w_empty[k] ? '0 : w_head[k];
    end

    assign out_valid = ~w_empty;
    assign out1      = w_out[0];
    assign out2      = w_out[1];
    assign out3      = w_out[2];
    assign out4      = w_out[3];

endmodule

// File: tb/tb_demux1to4_buf.sv
module tb_demux1to4_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1, out2, out3, out4;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q [4][$];

    demux1to4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] out_of(input int k);
        case (k)
            0: return out1;
            1: return out2;
            2: return out3;
            default: return out4;
        endcase
    endfunction

    initial begin
        logic             exp_rdy;
        logic [WIDTH-1:0] exp_head;
        logic [3:0]       pops;

        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = 2'b00;
        in_valid  = 1'b0;
        out_ready = 4'b0000;

        // Reset state
        tick(); tick();
        check("rst_valid", {28'b0, out_valid}, 32'h0);
        check("rst_out1", out1, 32'h0);
        check("rst_out4", out4, 32'h0);
        check("rst_ready", {31'b0, in_ready}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", {31'b0, in_ready}, 32'h1);

        // One word to each channel in successive cycles, consumers always ready
        out_ready = 4'b1111;
        in_valid = 1'b1; in_sel = 2'b00; in_data = 32'd0;
        tick();
        check("seq_v1", {28'b0, out_valid}, 32'h1);
        check("seq_o1", out1, 32'h0);
        in_sel = 2'b01; in_data = 32'd1;
        tick();
        check("seq_v2", {28'b0, out_valid}, 32'h2);
        check("seq_o2", out2, 32'h1);
        in_sel = 2'b10; in_data = 32'd0;
        tick();
        check("seq_v3", {28'b0, out_valid}, 32'h4);
        check("seq_o3", out3, 32'h0);
        in_sel = 2'b11; in_data = 32'd1;
        tick();
        check("seq_v4", {28'b0, out_valid}, 32'h8);
        check("seq_o4", out4, 32'h1);
        in_valid = 1'b0;
        tick();
        check("seq_drain", {28'b0, out_valid}, 32'h0);

        // Fill channel 1, third push refused, then drain
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'b00; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        #1;
        check("f1_rdy_B", {31'b0, in_ready}, 32'h1);
        tick();
        in_data = 32'hC;
        #1;
        check("f1_rdy_C", {31'b0, in_ready}, 32'h0);
        tick();
        check("f1_head_A", out1, 32'hA);
        out_ready = 4'b0001;
        #1;
        check("f1_rdy_popcyc", {31'b0, in_ready}, 32'h0);
        tick();
        check("f1_head_B", out1, 32'hB);
        check("f1_rdy_after", {31'b0, in_ready}, 32'h1);
        in_valid = 1'b0;
        tick();
        check("f1_empty_v", {28'b0, out_valid}, 32'h0);
        check("f1_empty_o", out1, 32'h0);

        // Channel 2 full and popping: push to it refused, channel 3 accepted
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'b01; in_data = 32'h21;
        tick();
        in_data = 32'h22;
        tick();
        out_ready = 4'b0010;
        in_data = 32'h23;
        #1;
        check("f2_rdy_full", {31'b0, in_ready}, 32'h0);
        in_sel = 2'b10; in_data = 32'h31;
        #1;
        check("f2_rdy_ch3", {31'b0, in_ready}, 32'h1);
        tick();
        check("f2_head", out2, 32'h22);
        check("f2_ch3", out3, 32'h31);
        check("f2_valid", {28'b0, out_valid}, 32'h6);
        in_valid = 1'b0;
        out_ready = 4'b0110;
        tick();
        check("f2_no_23", {28'b0, out_valid}, 32'h0);

        // Channel 4 steady at count 1 with push+pop, across pointer wrap
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'b11; in_data = 32'h40;
        tick();
        exp_head = 32'h40;
        out_ready = 4'b1000;
        for (int i = 0; i < 2*DEPTH+1; i++) begin
            in_data = 32'h55 + 32'(i);
            #1;
            check("w4_rdy", {31'b0, in_ready}, 32'h1);
            check("w4_pre", out4, exp_head);
            tick();
            exp_head = 32'h55 + 32'(i);
            check("w4_valid", {28'b0, out_valid}, 32'h8);
            check("w4_post", out4, exp_head);
        end
        in_valid = 1'b0;
        tick();
        check("w4_drain", {28'b0, out_valid}, 32'h0);

        // Asynchronous reset with words buffered in every channel
        out_ready = 4'b0000;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_sel = 2'(k); in_data = 32'h100 + 32'(k);
            tick();
        end
        check("ar_loaded", {28'b0, out_valid}, 32'hF);
        in_sel = 2'b00; in_data = 32'hDEAD;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {28'b0, out_valid}, 32'h0);
        check("ar_out1", out1, 32'h0);
        check("ar_out2", out2, 32'h0);
        check("ar_out3", out3, 32'h0);
        check("ar_out4", out4, 32'h0);
        check("ar_rdy", {31'b0, in_ready}, 32'h0);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("ar_rdy_rel", {31'b0, in_ready}, 32'h1);
        tick();
        check("ar_stale", {28'b0, out_valid}, 32'h0);
        check("ar_stale_o1", out1, 32'h0);

        // Random traffic against per-channel queues
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = 4'($urandom_range(0, 15));
            #1;
            exp_rdy = (q[in_sel].size() < DEPTH);
            check("rnd_rdy", {31'b0, in_ready}, {31'b0, exp_rdy});
            for (int k = 0; k < 4; k++) begin
                exp_head = (q[k].size() != 0) ? q[k][0] : '0;
                check("rnd_valid", {31'b0, out_valid[k]}, {31'b0, (q[k].size() != 0)});
                check("rnd_head", out_of(k), exp_head);
            end
            for (int k = 0; k < 4; k++)
                pops[k] = out_ready[k] && (q[k].size() != 0);
            for (int k = 0; k < 4; k++)
                if (pops[k]) void'(q[k].pop_front());
            if (in_valid && exp_rdy) q[in_sel].push_back(in_data);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
